// File: rtl/rgh_glitch_seq_if.sv
// Pin bundle for the glitch sequencer: board-side inputs plus HANA/pad-side outputs.
// Latency: none, this is wiring only.
// Backpressure: none; every signal is a level and no handshake is involved.
interface rgh_glitch_seq_if #(
    parameter int ATT_W = 8
);
    logic             arm;
    logic             post_bit;
    logic             cpu_rst_sense_n;
    logic             i2c_send;
    logic             glitch_out;
    logic             done;
    logic             busy;
    logic [ATT_W-1:0] attempts;

    // Board or test side: drives arm and the raw pins, observes the results.
    modport master (
        output arm, post_bit, cpu_rst_sense_n,
        input  i2c_send, glitch_out, done, busy, attempts
    );

    // Sequencer side.
    modport slave (
        input  arm, post_bit, cpu_rst_sense_n,
        output i2c_send, glitch_out, done, busy, attempts
    );
endinterface

// File: rtl/rgh_glitch_seq.sv
// Glitch sequencer for the S-RGH Trinity image: counts POST toggles, drives the HANA slow/fast request, fires the CPU reset pulse and retries until boot.
// Latency: post_edge is 3 clk edges after a pin change (5 edges with POST_FILTER_EN); the pulse starts GLITCH_DELAY+1 cycles after the GLITCH_EDGE strobe.
// Backpressure: none; the I2C sender absorbs i2c_send level changes itself. Optional build macro: POST_FILTER_EN.
module rgh_glitch_seq #(
    parameter int          SLOW_EDGE    = 3,
    parameter int          GLITCH_EDGE  = 4,
    parameter logic [15:0] GLITCH_DELAY = 16'd1200,
    parameter logic [3:0]  PULSE_W      = 4'd2,
    parameter int          SUCCESS_EDGE = 8,
    parameter logic [23:0] TIMEOUT      = 24'd4800000,
    parameter int          ATT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    rgh_glitch_seq_if.slave  sq
);

    // FSM encoding kept as plain constants so older tools and scripts can decode it.
    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_WAIT_SLOW   = 4'd1;
    localparam logic [3:0] S_WAIT_GLITCH = 4'd2;
    localparam logic [3:0] S_DELAY       = 4'd3;
    localparam logic [3:0] S_PULSE       = 4'd4;
    localparam logic [3:0] S_RELEASE     = 4'd5;
    localparam logic [3:0] S_CHECK       = 4'd6;
    localparam logic [3:0] S_FAIL        = 4'd7;
    localparam logic [3:0] S_DONE        = 4'd8;

    localparam logic [7:0]       SLOW_E    = 8'(SLOW_EDGE);
    localparam logic [7:0]       GLITCH_E  = 8'(GLITCH_EDGE);
    localparam logic [7:0]       SUCCESS_E = 8'(SUCCESS_EDGE);
    localparam logic [ATT_W-1:0] ATT_MAX   = {ATT_W{1'b1}};
    localparam logic [ATT_W-1:0] ATT_ONE   = {{(ATT_W-1){1'b0}}, 1'b1};

    logic [3:0]       state;
    logic [7:0]       edge_cnt;
    logic [7:0]       cnt_inc;
    logic [15:0]      dly;
    logic [3:0]       pw;
    logic [23:0]      tmo;
    logic             i2c_q;
    logic             glitch_q;
    logic             done_q;
    logic [ATT_W-1:0] attempts_q;

    logic             post_s1;
    logic             post_s2;
    logic             post_edge;
    logic             rst_s1;
    logic             rst_s2;
    logic             rst_seen;

`ifdef POST_FILTER_EN
    logic             post_s3;
    logic             post_flt;
    logic             post_flt_d;

    // POST bit: 3-stage sync, then only accept a level seen on two consecutive samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_s1    <= 1'b0;
            post_s2    <= 1'b0;
            post_s3    <= 1'b0;
            post_flt   <= 1'b0;
            post_flt_d <= 1'b0;
            post_edge  <= 1'b0;
        end else begin
            post_s1    <= sq.post_bit;
            post_s2    <= post_s1;
            post_s3    <= post_s2;
            if (post_s2 == post_s3) begin
                post_flt <= post_s3;
            end
            post_flt_d <= post_flt;
            post_edge  <= post_flt ^ post_flt_d;
        end
    end
`else
    logic             post_d;

    // POST bit: 2-stage sync and a registered strobe on either transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_s1   <= 1'b0;
            post_s2   <= 1'b0;
            post_d    <= 1'b0;
            post_edge <= 1'b0;
        end else begin
            post_s1   <= sq.post_bit;
            post_s2   <= post_s1;
            post_d    <= post_s2;
            post_edge <= post_s2 ^ post_d;
        end
    end
`endif

    // CPU reset sense: 2-stage sync, then a registered "console is in reset" flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_s1   <= 1'b0;
            rst_s2   <= 1'b0;
            rst_seen <= 1'b0;
        end else begin
            rst_s1   <= sq.cpu_rst_sense_n;
            rst_s2   <= rst_s1;
            rst_seen <= ~rst_s2;
        end
    end

    // Saturating next value of the POST edge counter.
    assign cnt_inc = (edge_cnt == 8'hFF) ? edge_cnt : edge_cnt + 8'd1;

    // Main sequencer: disarm wins over everything, then per-state behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            edge_cnt   <= 8'd0;
            dly        <= 16'd0;
            pw         <= 4'd0;
            tmo        <= 24'd0;
            i2c_q      <= 1'b0;
            glitch_q   <= 1'b0;
            done_q     <= 1'b0;
            attempts_q <= '0;
        end else if (!sq.arm) begin
            state    <= S_IDLE;
            i2c_q    <= 1'b0;
            glitch_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    edge_cnt <= 8'd0;
                    state    <= S_WAIT_SLOW;
                end

                S_WAIT_SLOW: begin
                    if (rst_seen) begin
                        // Console reset before the glitch: start counting over.
                        edge_cnt <= 8'd0;
                        i2c_q    <= 1'b0;
                    end else if (post_edge) begin
                        edge_cnt <= cnt_inc;
                        if (cnt_inc == SLOW_E) begin
                            i2c_q <= 1'b1;
                            state <= S_WAIT_GLITCH;
                        end
                    end
                end

                S_WAIT_GLITCH: begin
                    if (rst_seen) begin
                        edge_cnt <= 8'd0;
                        i2c_q    <= 1'b0;
                        state    <= S_WAIT_SLOW;
                    end else if (post_edge) begin
                        edge_cnt <= cnt_inc;
                        if (cnt_inc == GLITCH_E) begin
                            if (GLITCH_DELAY == 16'd0) begin
                                // No delay: the pulse starts right after the strobe.
                                glitch_q <= 1'b1;
                                pw       <= PULSE_W;
                                state    <= S_PULSE;
                            end else begin
                                dly   <= GLITCH_DELAY;
                                state <= S_DELAY;
                            end
                        end
                    end
                end

                S_DELAY: begin
                    if (rst_seen) begin
                        edge_cnt <= 8'd0;
                        i2c_q    <= 1'b0;
                        state    <= S_WAIT_SLOW;
                    end else begin
                        // The pulse goes high on the edge where dly runs out.
                        dly <= dly - 16'd1;
                        if (dly <= 16'd1) begin
                            glitch_q <= 1'b1;
                            pw       <= PULSE_W;
                            state    <= S_PULSE;
                        end
                    end
                end

                S_PULSE: begin
                    // rst_seen is ignored here: the pulse itself pulls the CPU into reset.
                    if (pw <= 4'd1) begin
                        glitch_q <= 1'b0;
                        state    <= S_RELEASE;
                    end else begin
                        pw <= pw - 4'd1;
                    end
                end

                S_RELEASE: begin
                    i2c_q <= 1'b0;
                    tmo   <= TIMEOUT;
                    state <= S_CHECK;
                end

                S_CHECK: begin
                    if (post_edge) begin
                        edge_cnt <= cnt_inc;
                    end
                    // A success edge beats a timeout or reset sense on the same cycle.
                    if (post_edge && (cnt_inc == SUCCESS_E)) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else if (rst_seen || (tmo <= 24'd1)) begin
                        state <= S_FAIL;
                    end else begin
                        tmo <= tmo - 24'd1;
                    end
                end

                S_FAIL: begin
                    if (attempts_q != ATT_MAX) begin
                        attempts_q <= attempts_q + ATT_ONE;
                    end
                    edge_cnt <= 8'd0;
                    state    <= S_WAIT_SLOW;
                end

                S_DONE: begin
                    done_q   <= 1'b1;
                    i2c_q    <= 1'b0;
                    glitch_q <= 1'b0;
                end

                default: begin
                    i2c_q    <= 1'b0;
                    glitch_q <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign sq.i2c_send   = i2c_q;
    assign sq.glitch_out = glitch_q;
    assign sq.done       = done_q;
    assign sq.busy       = (state != S_IDLE) && (state != S_DONE);
    assign sq.attempts   = attempts_q;

endmodule

// File: tb/tb_rgh_glitch_seq.sv
// Directed bench for the glitch sequencer with GLITCH_DELAY=10, PULSE_W=2, TIMEOUT=1000.
// Latency: inputs change and outputs are sampled on the falling clock edge.
// Backpressure: none; stimulus is fixed cycle counts, so the run always ends.
`timescale 1ns/1ps
module tb_rgh_glitch_seq;

    localparam int ATT_W = 8;
`ifdef POST_FILTER_EN
    localparam int LAT_X = 2;
`else
    localparam int LAT_X = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    rgh_glitch_seq_if #(.ATT_W(ATT_W)) sq ();

    rgh_glitch_seq #(
        .SLOW_EDGE    (3),
        .GLITCH_EDGE  (4),
        .GLITCH_DELAY (16'd10),
        .PULSE_W      (4'd2),
        .SUCCESS_EDGE (8),
        .TIMEOUT      (24'd1000),
        .ATT_W        (ATT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sq  (sq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the falling edge from which the strobe is always 3 edges away.
    task automatic toggle();
        sq.post_bit = ~sq.post_bit;
        cyc(LAT_X);
    endtask

    // From WAIT_SLOW with edge_cnt=0: four toggles, then stop on the first CHECK cycle.
    task automatic run_to_check(input int gap);
        for (int i = 0; i < 4; i++) begin
            cyc(gap);
            toggle();
        end
        cyc(17);
    endtask

    initial begin
        int hi;
        rst                = 1'b1;
        sq.arm             = 1'b0;
        sq.post_bit        = 1'b0;
        sq.cpu_rst_sense_n = 1'b1;
        cyc(3);
        chk("rst_i2c",    32'(sq.i2c_send),   0);
        chk("rst_glitch", 32'(sq.glitch_out), 0);
        chk("rst_done",   32'(sq.done),       0);
        chk("rst_busy",   32'(sq.busy),       0);
        chk("rst_att",    32'(sq.attempts),   0);
        rst = 1'b0;
        cyc(5);
        chk("idle_busy", 32'(sq.busy), 0);

        // Happy path
        sq.arm = 1'b1;
        cyc(2);
        chk("arm_busy", 32'(sq.busy), 1);
        cyc(100); toggle();
        cyc(100); toggle();
        cyc(100); toggle();
        cyc(3);  chk("slow_early", 32'(sq.i2c_send), 0);
        cyc(1);  chk("slow_rise",  32'(sq.i2c_send), 1);
        cyc(96); toggle();
        cyc(13); chk("pulse_early", 32'(sq.glitch_out), 0);
        cyc(1);  chk("pulse_start", 32'(sq.glitch_out), 1);
        chk("pulse_i2c", 32'(sq.i2c_send), 1);
        cyc(1);  chk("pulse_2nd",   32'(sq.glitch_out), 1);
        cyc(1);  chk("pulse_end",   32'(sq.glitch_out), 0);
        chk("i2c_hold", 32'(sq.i2c_send), 1);
        cyc(1);  chk("i2c_fall",    32'(sq.i2c_send), 0);
        chk("check_busy", 32'(sq.busy), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(20);
            toggle();
        end
        cyc(3);  chk("done_early", 32'(sq.done), 0);
        cyc(2);  chk("done_set",   32'(sq.done), 1);
        chk("done_busy", 32'(sq.busy),     0);
        chk("done_att",  32'(sq.attempts), 0);
        chk("done_i2c",  32'(sq.i2c_send), 0);
        sq.arm = 1'b0;
        cyc(1);
        chk("disarm_done", 32'(sq.done), 0);
        chk("disarm_busy", 32'(sq.busy), 0);

        // Timeout in CHECK
        sq.arm = 1'b1;
        cyc(2);
        run_to_check(5);
        cyc(1000); chk("tmo_early", 32'(sq.attempts), 0);
        cyc(1);    chk("tmo_fail",  32'(sq.attempts), 1);
        chk("tmo_busy", 32'(sq.busy), 1);
        cyc(5); toggle();
        cyc(5); toggle();
        cyc(5); toggle();
        cyc(3); chk("retry_early", 32'(sq.i2c_send), 0);
        cyc(1); chk("retry_slow",  32'(sq.i2c_send), 1);

        // Reset sense in CHECK
        cyc(5); toggle();
        cyc(17);
        sq.cpu_rst_sense_n = 1'b0;
        cyc(4); chk("sense_early", 32'(sq.attempts), 1);
        cyc(1); chk("sense_fail",  32'(sq.attempts), 2);
        sq.cpu_rst_sense_n = 1'b1;
        chk("sense_i2c", 32'(sq.i2c_send), 0);
        cyc(10);

        // Reset sense seen only while the pulse is high
        for (int i = 0; i < 3; i++) begin
            cyc(5);
            toggle();
        end
        cyc(5); toggle();
        cyc(11); sq.cpu_rst_sense_n = 1'b0;
        cyc(2);  sq.cpu_rst_sense_n = 1'b1;
        cyc(1);  chk("psense_pulse", 32'(sq.glitch_out), 1);
        cyc(3);  chk("psense_i2c",   32'(sq.i2c_send),   0);
        cyc(10); chk("psense_att",   32'(sq.attempts),   2);
        chk("psense_busy", 32'(sq.busy), 1);

        // Disarm in the middle of DELAY
        sq.arm = 1'b0;
        cyc(2);
        sq.arm = 1'b1;
        cyc(2);
        run_to_check(5);
        // run_to_check ended in CHECK; go round once more and stop inside DELAY
        sq.arm = 1'b0;
        cyc(2);
        sq.arm = 1'b1;
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            cyc(5);
            toggle();
        end
        cyc(8);
        chk("dly_i2c",    32'(sq.i2c_send),   1);
        chk("dly_glitch", 32'(sq.glitch_out), 0);
        sq.arm = 1'b0;
        cyc(1);
        chk("dis_i2c",    32'(sq.i2c_send),   0);
        chk("dis_glitch", 32'(sq.glitch_out), 0);
        chk("dis_busy",   32'(sq.busy),       0);
        hi = 0;
        repeat (30) begin
            cyc(1);
            if (sq.glitch_out) hi++;
        end
        chk("dis_no_pulse", 32'(hi), 0);
        chk("dis_att", 32'(sq.attempts), 2);

        // Async reset while the pulse is high
        sq.arm = 1'b1;
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            cyc(5);
            toggle();
        end
        cyc(14);
        chk("arst_pre", 32'(sq.glitch_out), 1);
        rst         = 1'b1;
        sq.post_bit = 1'b0;
        #1;
        chk("arst_glitch", 32'(sq.glitch_out), 0);
        chk("arst_att",    32'(sq.attempts),   0);
        chk("arst_i2c",    32'(sq.i2c_send),   0);
        cyc(1);
        rst = 1'b0;
        cyc(5);

        // Saturation of the attempt counter
        for (int i = 0; i < 260; i++) begin
            run_to_check(3);
            sq.cpu_rst_sense_n = 1'b0;
            cyc(5);
            sq.cpu_rst_sense_n = 1'b1;
            chk("sat_att", 32'(sq.attempts), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
            cyc(6);
        end

`ifdef POST_FILTER_EN
        // One-cycle glitch on the POST pin is dropped by the filter
        sq.arm = 1'b0;
        cyc(2);
        sq.arm = 1'b1;
        cyc(2);
        toggle();
        cyc(10);
        chk("flt_first", 32'(dut.edge_cnt), 1);
        sq.post_bit = ~sq.post_bit;
        cyc(1);
        sq.post_bit = ~sq.post_bit;
        cyc(10);
        chk("flt_glitch", 32'(dut.edge_cnt), 1);
        toggle();
        cyc(6);
        chk("flt_edge", 32'(dut.edge_cnt), 2);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/rgh_glitch_seq.md
Name: rgh_glitch_seq

Overview:
- Glitch sequencer for the S-RGH Trinity image.
- Tracks POST bus toggles and drives the `i2c_send` request of the HANA I2C sender: 1 = slowdown message, 0 = speedup message.
- Times and emits the CPU reset glitch pulse, then judges the attempt as success or failure.
- Sits between the board pins (POST bit, CPU reset sense) and the HANA I2C sender; retries automatically until a boot succeeds.

Parameters:
- SLOW_EDGE, 3: POST edge count at which slowdown is requested.
- GLITCH_EDGE, 4: POST edge count that starts the glitch delay.
- GLITCH_DELAY, 16'd1200: clk cycles from the GLITCH_EDGE strobe to the pulse start; 16-bit.
- PULSE_W, 4'd2: reset pulse width in clk cycles; 1..15.
- SUCCESS_EDGE, 8: POST edge count that declares success.
- TIMEOUT, 24'd4800000: clk cycles allowed in CHECK before the attempt fails.
- ATT_W, 8: attempt counter width.

Ports:
- clk, in, 1: main clock.
- rst, in, 1: asynchronous, active-high reset.
- arm, in, 1: level; 1 enables sequencing.
- post_bit, in, 1: async POST bus bit.
- cpu_rst_sense_n, in, 1: async console CPU reset line, low = in reset.
- i2c_send, out, 1: request to the HANA I2C sender; 1 = slow, 0 = fast.
- glitch_out, out, 1: reset glitch pulse, active high. Pad logic makes it open-drain.
- done, out, 1: sticky success flag.
- busy, out, 1: 1 in any state other than IDLE and DONE.
- attempts, out, ATT_W: failed-attempt count; saturates at all-ones.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - i2c_send=0, glitch_out=0, done=0, busy=0, attempts=0.
  - edge_cnt=0; all counters and sync FFs cleared.
- Input synchronisation:
  - post_bit and cpu_rst_sense_n each pass through 2 FFs.
  - post_edge is a registered one-cycle strobe on either transition of synced post_bit.
  - Latency: exactly 3 clk edges after the pin change.
  - rst_seen is registered from synced cpu_rst_sense_n == 0.
- edge_cnt is 8 bits:
  - Increments on post_edge in WAIT_SLOW, WAIT_GLITCH and CHECK.
  - Saturates at 255.
- States:
  - IDLE: arm=1 -> WAIT_SLOW with edge_cnt=0.
  - WAIT_SLOW: on the post_edge that makes edge_cnt == SLOW_EDGE, i2c_send=1 from the next cycle; -> WAIT_GLITCH.
  - WAIT_GLITCH: on the post_edge that makes edge_cnt == GLITCH_EDGE, load dly=GLITCH_DELAY; -> DELAY.
  - DELAY: dly decrements by 1 per cycle. On dly==0 -> PULSE with glitch_out=1 the next cycle. GLITCH_DELAY=0 gives the pulse 1 cycle after the strobe.
  - PULSE: glitch_out stays high for exactly PULSE_W cycles, then 0; -> RELEASE.
  - RELEASE: one cycle; i2c_send=0 (speedup request); load tmo=TIMEOUT; -> CHECK.
  - CHECK:
    - edge_cnt == SUCCESS_EDGE -> DONE.
    - tmo reaches 0 -> FAIL.
    - rst_seen -> FAIL.
  - FAIL: one cycle; attempts += 1 (saturating); edge_cnt=0; -> WAIT_SLOW.
  - DONE: done=1 (sticky); i2c_send=0; glitch_out=0. Leaves only on rst or arm=0.
- Abort and precedence:
  - rst_seen in WAIT_SLOW, WAIT_GLITCH or DELAY: i2c_send=0, edge_cnt=0, stay or return to WAIT_SLOW; attempts unchanged.
  - rst_seen in PULSE: ignored, because the pulse itself causes it.
  - arm=0 in any state: next cycle -> IDLE, i2c_send=0, glitch_out=0, done=0; attempts held.
  - arm=0 has priority over all other transitions.
  - A simultaneous post_edge and timeout in CHECK resolves as success if that edge reaches SUCCESS_EDGE.
- Pulse integrity:
  - glitch_out never exceeds PULSE_W cycles.
  - glitch_out is never high outside PULSE, except when async rst clears it immediately.
- i2c_send changes at most once per state transition. The I2C sender handles in-flight messages and its own slowdown delay.

Optional Feature:
- Macro: POST_FILTER_EN.
- Defined:
  - A 3rd sync stage plus 2-of-2 agreement filter on post_bit.
  - A transition is accepted only after 2 consecutive equal samples.
  - post_edge latency is 5 clk edges; single-cycle glitches on post_bit are ignored.
- Undefined: the 2-FF path only, 3-edge latency, no filtering.
- GLITCH_DELAY is always counted from the post_edge strobe in either build.

Test Plan:
- Happy path:
  - Stimulus: rst, arm=1, toggle post_bit 4 times spaced 100 cycles, GLITCH_DELAY=10.
  - Response: i2c_send rises 1 cycle after the 3rd strobe; glitch_out high exactly 2 cycles, starting 11 cycles after the 4th strobe; i2c_send falls 1 cycle after the pulse.
  - Continuation: 4 more toggles -> done=1, busy=0, attempts=0.
- Timeout:
  - Stimulus: TIMEOUT=1000, no POST edges after the pulse.
  - Response: FAIL after 1000 cycles in CHECK; attempts=1; sequence restarts, and the next 3 edges re-raise i2c_send.
- Reset sense:
  - Stimulus: drive cpu_rst_sense_n low for 5 cycles in CHECK.
  - Response: attempts increments by 1; low during PULSE leaves attempts unchanged.
- Disarm:
  - Stimulus: arm=0 mid-DELAY.
  - Response: next cycle i2c_send=0, glitch_out=0, state IDLE, and no pulse is ever emitted.
- Async reset:
  - Stimulus: rst asserted while glitch_out=1.
  - Response: glitch_out=0 with no clock edge required; attempts=0.
- Saturation:
  - Stimulus: force 260 failed attempts with ATT_W=8.
  - Response: attempts holds at 255.
- Filter build:
  - Stimulus: POST_FILTER_EN defined, 1-cycle post_bit glitch.
  - Response: edge_cnt unchanged.
